// File: rtl/text_term_buffer.sv
// Character terminal buffer: byte-stream input with cursor, line wrap and
// pointer-based hardware scrolling, plus a one-cycle-latency video read port.
module text_term_buffer #(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 25,
  parameter int         COL_BITS   = 7,
  parameter int         ROW_BITS   = 5,
  parameter int         ADDR_BITS  = 11,
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                clear,
  input  logic [COL_BITS-1:0] rd_col,
  input  logic [ROW_BITS-1:0] rd_row,
  output logic [7:0]          rd_data,
  output logic [COL_BITS-1:0] cursor_col,
  output logic [ROW_BITS-1:0] cursor_row,
  output logic [ROW_BITS-1:0] top_row
);

  localparam int                  TOTAL     = COLS * ROWS;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(TOTAL - 1);
  localparam logic [COL_BITS-1:0]  LAST_COL  = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0]  LAST_ROW  = ROW_BITS'(ROWS - 1);
  localparam logic [ROW_BITS:0]    ROWS_W    = (ROW_BITS + 1)'(ROWS);
  localparam logic [COL_BITS:0]    COLS_W    = (COL_BITS + 1)'(COLS);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_SCROLL
  } state_t;

  state_t                r_state, w_state_next;
  logic [COL_BITS-1:0]   r_col, w_col_next;
  logic [ROW_BITS-1:0]   r_row, w_row_next;
  logic [ROW_BITS-1:0]   r_top, w_top_next;
  logic [ADDR_BITS-1:0]  r_clr_addr, w_clr_addr_next;
  logic [COL_BITS-1:0]   r_scroll_col, w_scroll_col_next;
  logic [ADDR_BITS-1:0]  r_scroll_base, w_scroll_base_next;
  logic [7:0]            r_rd_data;
  logic [7:0]            r_mem [0:TOTAL-1];

  logic                  w_accept;
  logic                  w_clear_req;
  logic                  w_newline;
  logic                  w_we;
  logic [ADDR_BITS-1:0]  w_waddr;
  logic [7:0]            w_wdata;
  logic                  w_rd_oob;
  logic [ADDR_BITS-1:0]  w_rd_addr;

  // Logical row -> physical row is a single compare-and-subtract since both
  // operands are below ROWS.
  function automatic logic [ADDR_BITS-1:0] phys_addr(input logic [ROW_BITS-1:0] row,
                                                     input logic [ROW_BITS-1:0] top,
                                                     input logic [COL_BITS-1:0] col);
    logic [ROW_BITS:0] sum;
    sum = {1'b0, row} + {1'b0, top};
    if (sum >= ROWS_W) sum = sum - ROWS_W;
    return ADDR_BITS'(sum) * ADDR_BITS'(COLS) + ADDR_BITS'(col);
  endfunction

  assign in_ready    = (r_state == S_IDLE) && !clear;
  assign w_accept    = in_valid && in_ready;
  assign w_clear_req = clear || (w_accept && (in_data == 8'h0C));

  assign rd_data     = r_rd_data;
  assign cursor_col  = r_col;
  assign cursor_row  = r_row;
  assign top_row     = r_top;

  always_comb begin
    w_state_next       = r_state;
    w_col_next         = r_col;
    w_row_next         = r_row;
    w_top_next         = r_top;
    w_clr_addr_next    = r_clr_addr;
    w_scroll_col_next  = r_scroll_col;
    w_scroll_base_next = r_scroll_base;
    w_newline          = 1'b0;
    w_we               = 1'b0;
    w_waddr            = '0;
    w_wdata            = CLEAR_CHAR;

    if (w_clear_req) begin
      w_state_next    = S_CLEAR;
      w_clr_addr_next = '0;
      w_col_next      = '0;
      w_row_next      = '0;
      w_top_next      = '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          w_we    = 1'b1;
          w_waddr = r_clr_addr;
          if (r_clr_addr == LAST_ADDR) w_state_next = S_IDLE;
          else                         w_clr_addr_next = r_clr_addr + 1'b1;
        end
        S_SCROLL: begin
          w_we    = 1'b1;
          w_waddr = r_scroll_base + ADDR_BITS'(r_scroll_col);
          if (r_scroll_col == LAST_COL) w_state_next = S_IDLE;
          else                          w_scroll_col_next = r_scroll_col + 1'b1;
        end
        default: begin
          if (w_accept) begin
            if (in_data >= 8'h20) begin
              w_we    = 1'b1;
              w_waddr = phys_addr(r_row, r_top, r_col);
              w_wdata = in_data;
              if (r_col == LAST_COL) w_newline = 1'b1;
              else                   w_col_next = r_col + 1'b1;
            end else if (in_data == 8'h0D) begin
              w_col_next = '0;
            end else if (in_data == 8'h0A) begin
              w_newline = 1'b1;
            end else if (in_data == 8'h08) begin
              if (r_col != '0) w_col_next = r_col - 1'b1;
            end
          end
          if (w_newline) begin
            w_col_next = '0;
            if (r_row != LAST_ROW) begin
              w_row_next = r_row + 1'b1;
            end else begin
              // The old top line becomes the new bottom line and must be blanked.
              w_top_next         = (r_top == LAST_ROW) ? '0 : r_top + 1'b1;
              w_scroll_base_next = phys_addr('0, r_top, '0);
              w_scroll_col_next  = '0;
              w_state_next       = S_SCROLL;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_CLEAR;
      r_col         <= '0;
      r_row         <= '0;
      r_top         <= '0;
      r_clr_addr    <= '0;
      r_scroll_col  <= '0;
      r_scroll_base <= '0;
    end else begin
      r_state       <= w_state_next;
      r_col         <= w_col_next;
      r_row         <= w_row_next;
      r_top         <= w_top_next;
      r_clr_addr    <= w_clr_addr_next;
      r_scroll_col  <= w_scroll_col_next;
      r_scroll_base <= w_scroll_base_next;
    end
  end

  assign w_rd_oob  = ({1'b0, rd_row} >= ROWS_W) || ({1'b0, rd_col} >= COLS_W);
  assign w_rd_addr = w_rd_oob ? '0 : phys_addr(rd_row, r_top, rd_col);

  always_ff @(posedge clk) begin
    if (w_we && !reset) r_mem[w_waddr] <= w_wdata;
  end

  // Read-before-write: a same-cycle write to the read address returns old data.
  always_ff @(posedge clk) begin
    if (reset)         r_rd_data <= 8'h00;
    else if (w_rd_oob) r_rd_data <= CLEAR_CHAR;
    else               r_rd_data <= r_mem[w_rd_addr];
  end

endmodule

// File: tb/tb_text_term_buffer.sv
// Directed self-checking bench for text_term_buffer: clear timing, cursor
// handling, wrap, scroll, clear abort and read-port corner cases.
module tb_text_term_buffer;

  localparam int COLS = 80;
  localparam int ROWS = 25;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       clear;
  logic [6:0] rd_col;
  logic [4:0] rd_row;
  logic [7:0] rd_data;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic [4:0] top_row;

  int n_compared   = 0;
  int n_mismatched = 0;

  text_term_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .clear      (clear),
    .rd_col     (rd_col),
    .rd_row     (rd_row),
    .rd_data    (rd_data),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .top_row    (top_row)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited   = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && waited < 5000) begin
      tick();
      waited++;
    end
    if (!in_ready) check_eq("send_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
    $display("send %02h -> cursor=(%0d,%0d) top=%0d", b, cursor_row, cursor_col, top_row);
  endtask

  task automatic read_cell(input logic [4:0] row, input logic [6:0] col, output logic [7:0] d);
    rd_row = row;
    rd_col = col;
    tick();
    d = rd_data;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (!in_ready && cnt < 5000) begin
      cnt++;
      tick();
    end
  endtask

  logic [7:0] d;
  int         busy;

  initial begin
    reset    = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;
    clear    = 1'b0;
    rd_col   = '0;
    rd_row   = '0;

    tick();
    check_eq("rst_rd_data", rd_data, 8'h00);
    check_eq("rst_cur_col", cursor_col, 0);
    check_eq("rst_cur_row", cursor_row, 0);
    check_eq("rst_top_row", top_row, 0);
    check_eq("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    count_busy(busy);
    check_eq("rst_clear_len", busy, 2000);

    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        read_cell(5'(r), 7'(c), d);
        check_eq("blank_after_reset", d, 8'h20);
      end

    // "AB", CR, "C"
    send_byte(8'h41);
    send_byte(8'h42);
    send_byte(8'h0D);
    send_byte(8'h43);
    read_cell(0, 0, d); check_eq("cr_cell00", d, 8'h43);
    read_cell(0, 1, d); check_eq("cr_cell01", d, 8'h42);
    check_eq("cr_cur_row", cursor_row, 0);
    check_eq("cr_cur_col", cursor_col, 1);

    // Form feed behaves like a clear request
    send_byte(8'h0C);
    check_eq("ff_cur_col", cursor_col, 0);
    count_busy(busy);
    check_eq("ff_clear_len", busy, 2000);
    read_cell(0, 0, d); check_eq("ff_cell00", d, 8'h20);

    // Fill one full line: wraps to row 1 without scrolling
    for (int i = 0; i < COLS; i++) send_byte(8'h41);
    check_eq("wrap_cur_row", cursor_row, 1);
    check_eq("wrap_cur_col", cursor_col, 0);
    check_eq("wrap_top_row", top_row, 0);
    check_eq("wrap_ready", in_ready, 1);
    for (int c = 0; c < COLS; c++) begin
      read_cell(0, 7'(c), d);
      check_eq("wrap_row0", d, 8'h41);
    end
    read_cell(1, 0, d); check_eq("wrap_cell10", d, 8'h20);
    send_byte(8'h08);
    check_eq("bs_col0_col", cursor_col, 0);
    check_eq("bs_col0_row", cursor_row, 1);

    // Marker on row 1, then newlines down to the bottom and one scroll
    send_byte(8'h53);
    send_byte(8'h08);
    check_eq("bs_col", cursor_col, 0);
    read_cell(1, 0, d); check_eq("bs_no_erase", d, 8'h53);
    send_byte(8'h07);
    check_eq("ctl_ignored", cursor_col, 0);
    for (int i = 0; i < ROWS - 2; i++) send_byte(8'h0A);
    check_eq("bottom_row", cursor_row, 24);
    check_eq("bottom_top", top_row, 0);
    send_byte(8'h0A);
    check_eq("scroll_top", top_row, 1);
    check_eq("scroll_cur_row", cursor_row, 24);
    count_busy(busy);
    check_eq("scroll_len", busy, 80);
    send_byte(8'h5A);
    check_eq("z_cur_col", cursor_col, 1);
    read_cell(24, 0, d); check_eq("z_cell", d, 8'h5A);
    for (int c = 1; c < COLS; c++) begin
      read_cell(24, 7'(c), d);
      check_eq("scrolled_blank", d, 8'h20);
    end
    read_cell(0, 0, d); check_eq("old_row1_at_0", d, 8'h53);
    read_cell(0, 1, d); check_eq("old_row1_col1", d, 8'h20);

    // Clear in the middle of a scroll with a byte pending
    send_byte(8'h0A);
    check_eq("scroll2_top", top_row, 2);
    for (int i = 0; i < 5; i++) tick();
    in_data  = 8'h4B;
    in_valid = 1'b1;
    clear    = 1'b1;
    #1;
    check_eq("clr_ready_low", in_ready, 0);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check_eq("clr_top", top_row, 0);
    check_eq("clr_cur_row", cursor_row, 0);
    count_busy(busy);
    check_eq("clr_abort_len", busy, 2000);
    check_eq("clr_cur_col", cursor_col, 0);
    read_cell(0, 0, d); check_eq("clr_not_consumed", d, 8'h20);
    read_cell(24, 0, d); check_eq("clr_bottom", d, 8'h20);

    // Out-of-range reads
    send_byte(8'h4D);
    read_cell(0, 0, d);   check_eq("m_cell", d, 8'h4D);
    read_cell(30, 0, d);  check_eq("oob_row", d, 8'h20);
    read_cell(0, 100, d); check_eq("oob_col", d, 8'h20);

    // Read and write of the same cell in one cycle
    rd_row   = 0;
    rd_col   = 1;
    in_data  = 8'h4E;
    in_valid = 1'b1;
    #1;
    check_eq("raw_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check_eq("raw_old_data", rd_data, 8'h20);
    tick();
    check_eq("raw_new_data", rd_data, 8'h4E);
    check_eq("raw_cur_col", cursor_col, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
